// File: rtl/regfile_write_arbiter_if.sv
// Writeback bundle between the two writeback sources / issue logic and the register-file write arbiter.
// The master side drives requests and hazard queries; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              pend_set;
  logic [ADDR_W-1:0] pend_rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              reg_write;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] rd_din;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
           pend_set, pend_rd, rs1, rs2,
    input  a_ready, b_ready, rs1_busy, rs2_busy, reg_write, rd, rd_din
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
           pend_set, pend_rd, rs1, rs2,
    output a_ready, b_ready, rs1_busy, rs2_busy, reg_write, rd, rd_din
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between core (A) and long-latency (B) writeback,
// with a pending-write scoreboard for B destinations. Define REGFILE_ARB_STATS_EN to add conflict_cnt.
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [31:0]            conflict_cnt
`endif
);

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  grant_e              last_grant_q;
  grant_e              last_grant_d;
  logic                a_ready_c;
  logic                b_ready_c;

  logic                sel_vld_p0;
  logic [ADDR_W-1:0]   sel_rd_p0;
  logic [DATA_W-1:0]   sel_data_p0;

  logic                wr_vld_p1;
  logic [ADDR_W-1:0]   wr_rd_p1;
  logic [DATA_W-1:0]   wr_data_p1;

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  function automatic logic busy_of(input logic [NUM_REGS-1:0] pend,
                                   input logic [ADDR_W-1:0]   idx);
    return (idx != '0) && pend[idx];
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= GRANT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // Grant the only requester, or on a conflict the one that did not win last time.
  always_comb begin
    a_ready_c    = 1'b0;
    b_ready_c    = 1'b0;
    last_grant_d = last_grant_q;
    if (reset) begin
      if (bus.a_valid && (!bus.b_valid || (last_grant_q == GRANT_B))) begin
        a_ready_c    = 1'b1;
        last_grant_d = GRANT_A;
      end else if (bus.b_valid) begin
        b_ready_c    = 1'b1;
        last_grant_d = GRANT_B;
      end
    end
  end

  assign bus.a_ready = a_ready_c;
  assign bus.b_ready = b_ready_c;

  // Stage p0: select the granted source; x0 is accepted but never written.
  always_comb begin
    sel_vld_p0  = 1'b0;
    sel_rd_p0   = bus.a_rd;
    sel_data_p0 = bus.a_data;
    if (a_ready_c) begin
      sel_vld_p0 = (bus.a_rd != '0);
    end else if (b_ready_c) begin
      sel_vld_p0  = (bus.b_rd != '0);
      sel_rd_p0   = bus.b_rd;
      sel_data_p0 = bus.b_data;
    end
  end

  // Stage p1: registered write port; index and data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_vld_p1  <= 1'b0;
      wr_rd_p1   <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_vld_p1 <= sel_vld_p0;
      if (a_ready_c || b_ready_c) begin
        wr_rd_p1   <= sel_rd_p0;
        wr_data_p1 <= sel_data_p0;
      end
    end
  end

  assign bus.reg_write = wr_vld_p1;
  assign bus.rd        = wr_rd_p1;
  assign bus.rd_din    = wr_data_p1;

  // Clear on B accept first so a same-edge issue to that register keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (b_ready_c && (bus.b_rd != '0)) begin
      pending_d[bus.b_rd] = 1'b0;
    end
    if (bus.pend_set && (bus.pend_rd != '0)) begin
      pending_d[bus.pend_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign bus.rs1_busy = busy_of(pending_q, bus.rs1);
  assign bus.rs2_busy = busy_of(pending_q, bus.rs2);

`ifdef REGFILE_ARB_STATS_EN
  logic [31:0] conflict_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      conflict_cnt_q <= 32'd0;
    end else if (bus.a_valid && bus.b_valid) begin
      conflict_cnt_q <= sat_inc32(conflict_cnt_q);
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  // The saturating increment exists only for the statistics build.
  logic [31:0] unused_sat_c;
  assign unused_sat_c = sat_inc32(32'd0);
`endif

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback sources.
  - Port A: single-cycle core writeback.
  - Port B: long-latency unit (load/mul/div).
- Registered output of the block drives the register file's reg_write/rd/rd_din directly.
- Also keeps a pending-write scoreboard for port-B destinations, so issue logic can stall on RAW hazards.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clk.
- a_valid  input  1  port A write request.
- a_rd  input  ADDR_W  port A destination.
- a_data  input  DATA_W  port A data.
- a_ready  output  1  port A accepted this cycle.
- b_valid  input  1  port B write request.
- b_rd  input  ADDR_W  port B destination.
- b_data  input  DATA_W  port B data.
- b_ready  output  1  port B accepted this cycle.
- pend_set  input  1  issue of a long-latency op targeting pend_rd.
- pend_rd  input  ADDR_W  destination being marked pending.
- rs1  input  ADDR_W  hazard query index 1.
- rs2  input  ADDR_W  hazard query index 2.
- rs1_busy  output  1  rs1 has an outstanding port-B write.
- rs2_busy  output  1  rs2 has an outstanding port-B write.
- reg_write  output  1  write enable to register file (registered).
- rd  output  ADDR_W  write index (registered).
- rd_din  output  DATA_W  write data (registered).

Behaviour:
- Reset (reset==0 at an edge):
  - reg_write=0, rd=0, rd_din=0.
  - Pending bits all 0.
  - last_grant=B, so A wins the first conflict.
  - a_ready=b_ready=0 while reset is low.
- Handshake:
  - A transfer happens on an edge where valid&&ready.
  - ready is combinational from the valids and last_grant.
  - Requesters must not make valid depend on ready.
  - An unaccepted request holds valid/rd/data stable until accepted.
- Arbitration, one grant per cycle:
  - Only one valid: grant it.
  - Both valid: grant the port that is not last_grant (round-robin).
  - last_grant updates to the granted port on every grant; unchanged when nothing is granted.
- Latency: a request accepted at edge N appears as reg_write=1 with rd/rd_din in cycle N+1 (written into the register file at edge N+1).
- No grant in a cycle: reg_write=0 next cycle; rd/rd_din hold their previous values.
- x0 request (rd index 0):
  - Accepted normally (ready asserted, arbitration pointer advances).
  - reg_write stays 0 for that slot.
- Scoreboard:
  - pend_set=1 with pend_rd!=0 sets pending[pend_rd] at the edge.
  - Accepting port B clears pending[b_rd] at the same edge.
  - Set and clear of the same index at the same edge: set wins (newly issued op).
  - pend_rd==0 is ignored.
  - rsN_busy = pending[rsN], combinational; always 0 for index 0.
  - Port A writes never touch pending bits.
- Reset while a request is waiting: the request is dropped, pending bits are cleared, and reg_write=0 on the cycle after reset deasserts.

Optional Feature:
- Macro: REGFILE_ARB_STATS_EN.
- When defined:
  - Adds output conflict_cnt [31:0]: counts edges where a_valid&&b_valid, i.e. one requester was forced to wait.
  - Saturates at 32'hFFFFFFFF.
  - Reset to 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset low 2 cycles, then release → reg_write=0, rs1_busy=0 for all rs1, a_ready=0 during reset.
- a_valid, a_rd=5, a_data=32'hDEADBEEF at edge N, b idle → a_ready=1; cycle N+1 reg_write=1, rd=5, rd_din=DEADBEEF; cycle N+2 reg_write=0.
- a and b valid 3 consecutive cycles (a_rd=1/a_data=1, b_rd=2/b_data=2, each held until accepted) → grant order A,B,A; reg_write pattern 1,1,1 with rd 1,2,1.
- pend_set with pend_rd=7, then rs1=7 → rs1_busy=1. Port B write rd=7 accepted → rs1_busy=0 after that edge. Repeat with pend_set=7 and b accept rd=7 on the same edge → rs1_busy stays 1.
- b_valid, b_rd=0, b_data=32'h1234 → b_ready=1, reg_write stays 0, next conflict grants A.
- With REGFILE_ARB_STATS_EN: 4 edges of both-valid and 2 of single-valid → conflict_cnt=4; reset → 0.
